box_arbiter: RTL and testbench
==============================

# box_arbiter

- Per-frame scheduler that decides which colour detector's bounding box the overlay stage draws, and with which label colour.
- Collects the red, green and blue detector boxes during a frame.
- At each vsync rising edge it runs a short sequential arbitration: validity check, area compare, multi-frame debounce and lost-target timeout.
- Drives the overlay's box coordinates, one-hot colour enables and label colour. Outputs change only during vertical blanking.

## Interface
- FRAME_HOLD, 3: consecutive frames a new winning class must persist before the displayed class switches (1..15).
- MIN_AREA, 400: minimum box area in pixels for a candidate to be valid.
- LOST_FRAMES, 8: consecutive frames with no valid candidate before the box is cleared (1..255).
- pixelclk  in  1  pixel clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_vsync  in  1  frame sync, active high; the same signal fed to the overlay.
- r_box_valid  in  1  one-cycle pulse: red detector box on r_box is valid.
- r_box  in  48  red box, packed {hl, hr, vl, vr}, 12 bits each.
- g_box_valid, g_box  in  1/48  green detector, same format as red.
- b_box_valid, b_box  in  1/48  blue detector, same format as red.
- hcount_l, hcount_r, vcount_l, vcount_r  out  12 each  displayed box edges.
- red_en, grenn_en, blue_en  out  1 each  one-hot displayed class; all 0 means none.
- r_t  out  24  label colour: ff0000 red, 00ff00 green, 0000ff blue, 000000 none.
- busy  out  1  high while arbitration runs (states other than IDLE).

## Operation
- **Candidate capture:** a valid pulse latches its box into that channel's candidate register and sets the channel flag. If several pulses arrive in one frame, the last one wins.
- **Frame edge:** edge = i_vsync & ~vsync_d, where vsync_d is i_vsync registered. On the edge cycle the three candidates and flags are copied into snapshot registers and the flags are cleared.
  - A valid pulse in that same cycle sets its flag after the clear, so it belongs to the new frame.
- **FSM states:** IDLE -> CALC_R -> CALC_G -> CALC_B -> DECIDE -> COMMIT -> IDLE.
  - IDLE leaves on the edge cycle.
  - Every other state lasts exactly 1 cycle.
  - An edge seen in any state other than IDLE is ignored, not queued.
- **CALC_x:** a snapshot is valid iff all of:
  - its flag is set;
  - hr > hl and vr > vl;
  - area = (hr-hl)*(vr-vl) >= MIN_AREA.
  - The area is 24-bit unsigned, computed from 12-bit differences, so it cannot overflow. An invalid channel's area is forced to 0.
- **DECIDE:**
  - The winner is the valid channel with the largest area. Ties resolve R > G > B.
  - If no channel is valid, the winner is NONE.
- **COMMIT, debounce:**
  - If winner == pending, stable_cnt increments, saturating at FRAME_HOLD.
  - Otherwise pending = winner and stable_cnt = 1.
- **COMMIT, winner not NONE:**
  - lost_cnt is cleared.
  - If winner == displayed class: coordinates are reloaded from the winner's snapshot (tracking).
  - Else if stable_cnt (after update) == FRAME_HOLD: the displayed class switches to the winner, and the enables, r_t and coordinates are all loaded from it.
  - Otherwise the outputs are held.
- **COMMIT, winner NONE:**
  - lost_cnt increments, saturating at LOST_FRAMES.
  - When it reaches LOST_FRAMES: enables, r_t and coordinates are all cleared to 0 and the displayed class becomes NONE.
  - Before that, the outputs are held.
- **Reset:** reset_n low at any time, including mid-arbitration, forces IDLE. All outputs, candidates, snapshots, flags and counters return to 0, and pending and displayed class return to NONE.

## Timing
- Reset value of every output is 0: coordinates, enables, r_t, busy.
- Edge in cycle E: snapshot taken at the end of E; busy is high in cycles E+1..E+5; all outputs update together at the end of E+5 (COMMIT).
- Latency from the first cycle i_vsync is sampled high to the new outputs being visible is 6 clocks.
- Outputs are constant between commits. The enables are always one-hot or all zero.
- Because cleared outputs are all 0 (hl=hr=vl=vr=0), the overlay draws nothing.

## Structure
- Package box_arbiter_pkg holds:
  - class encoding: CLS_NONE=0, CLS_R=1, CLS_G=2, CLS_B=3;
  - label colour constants;
  - the FSM state encoding;
  - box field offsets within the 48-bit bus.
- Sub-module box_area_check (combinational) takes a 48-bit box, its flag and MIN_AREA, and outputs valid and the 24-bit area. It is instanced once and multiplexed across the three CALC states.

## Test plan
- **Single red target:** red box {100,300,50,200} (area 30000) every frame, FRAME_HOLD=3. Enables stay 0 after commits 1 and 2. After commit 3: red_en=1, r_t=ff0000, coordinates 100/300/50/200, each update exactly 6 clocks after the vsync edge.
- **Area compare and tie:**
  - Green box area 40000 and red box area 30000 in the same frame: green wins.
  - Equal areas: red wins.
  - A box with hr <= hl, or area 399 with MIN_AREA=400, is never selected.
- **Tracking and switch:**
  - While red is displayed, the red box moves by 10 pixels per frame: coordinates follow on every commit.
  - Blue then dominates for 2 frames: no switch.
  - Blue dominates for 3 frames: switch to blue_en, r_t=0000ff.
- **Loss:** after the display is established, detections stop. Outputs are held for 7 commits and clear to all zero on the 8th (LOST_FRAMES=8).
- **Boundary events:**
  - A red valid pulse in the exact vsync edge cycle is counted in the next frame, not the current one.
  - A second vsync edge while busy=1 produces no extra commit.
  - Asserting reset_n=0 during CALC_G zeroes all outputs immediately, and the following frame restarts the debounce from 0.

Source files
------------

// File: rtl/box_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// box_arbiter_pkg : shared encodings for the per-frame colour box arbiter
// Revision 1.0
// ============================================================================
package box_arbiter_pkg;

    typedef enum logic [1:0] {
        CLS_NONE = 2'd0,
        CLS_R    = 2'd1,
        CLS_G    = 2'd2,
        CLS_B    = 2'd3
    } cls_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CALC_R = 3'd1,
        ST_CALC_G = 3'd2,
        ST_CALC_B = 3'd3,
        ST_DECIDE = 3'd4,
        ST_COMMIT = 3'd5
    } state_e;

    localparam logic [23:0] c_rgb_red  = 24'hff0000;
    localparam logic [23:0] c_rgb_grn  = 24'h00ff00;
    localparam logic [23:0] c_rgb_blu  = 24'h0000ff;
    localparam logic [23:0] c_rgb_none = 24'h000000;

    // Box bus is packed {hl, hr, vl, vr}
    localparam int c_field_w = 12;
    localparam int c_hl_lsb  = 36;
    localparam int c_hr_lsb  = 24;
    localparam int c_vl_lsb  = 12;
    localparam int c_vr_lsb  = 0;

    function automatic logic [23:0] label_colour(input cls_e cls);
        case (cls)
            CLS_R:   return c_rgb_red;
            CLS_G:   return c_rgb_grn;
            CLS_B:   return c_rgb_blu;
            default: return c_rgb_none;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/box_area_check.sv
`default_nettype none
// ============================================================================
// box_area_check : combinational validity test and area of one detector box
// Revision 1.0
// ============================================================================
module box_area_check
    import box_arbiter_pkg::*;
#(
    parameter int MIN_AREA = 400
) (
    input  logic [47:0] i_box,
    input  logic        i_flag,
    output logic        o_valid,
    output logic [23:0] o_area
);

    localparam logic [23:0] c_min_area = 24'(MIN_AREA);

    logic [11:0] w_hl, w_hr, w_vl, w_vr;
    logic [11:0] w_dh, w_dv;
    logic [23:0] w_area;
    logic        w_ok;

    always_comb begin
        w_hl = i_box[c_hl_lsb +: c_field_w];
        w_hr = i_box[c_hr_lsb +: c_field_w];
        w_vl = i_box[c_vl_lsb +: c_field_w];
        w_vr = i_box[c_vr_lsb +: c_field_w];
        w_dh = w_hr - w_hl;
        w_dv = w_vr - w_vl;
        // 12x12 product always fits in 24 bits
        w_area  = {12'd0, w_dh} * {12'd0, w_dv};
        w_ok    = i_flag && (w_hr > w_hl) && (w_vr > w_vl) && (w_area >= c_min_area);
        o_valid = w_ok;
        o_area  = w_ok ? w_area : 24'd0;
    end

endmodule
`default_nettype wire

// File: rtl/box_arbiter.sv
`default_nettype none
// ============================================================================
// box_arbiter : picks which colour detector box the overlay draws each frame
// Revision 1.0
// ============================================================================
module box_arbiter
    import box_arbiter_pkg::*;
#(
    parameter int FRAME_HOLD  = 3,
    parameter int MIN_AREA    = 400,
    parameter int LOST_FRAMES = 8
) (
    input  logic        pixelclk,
    input  logic        reset_n,
    input  logic        i_vsync,
    input  logic        r_box_valid,
    input  logic [47:0] r_box,
    input  logic        g_box_valid,
    input  logic [47:0] g_box,
    input  logic        b_box_valid,
    input  logic [47:0] b_box,
    output logic [11:0] hcount_l,
    output logic [11:0] hcount_r,
    output logic [11:0] vcount_l,
    output logic [11:0] vcount_r,
    output logic        red_en,
    output logic        grenn_en,
    output logic        blue_en,
    output logic [23:0] r_t,
    output logic        busy
);

    localparam logic [3:0] c_hold = 4'(FRAME_HOLD);
    localparam logic [7:0] c_lost = 8'(LOST_FRAMES);

    state_e           state_q, state_d;
    logic             vsync_q, vsync_d;
    logic [2:0][47:0] cand_q, cand_d, snap_q, snap_d;
    logic [2:0]       flag_q, flag_d, snap_flag_q, snap_flag_d;
    logic [2:0]       valid_q, valid_d;
    logic [2:0][23:0] area_q, area_d;
    cls_e             winner_q, winner_d, pending_q, pending_d, disp_q, disp_d;
    logic [3:0]       stable_q, stable_d;
    logic [7:0]       lost_q, lost_d;
    logic [47:0]      disp_box_q, disp_box_d;

    logic        w_start;
    logic [47:0] w_chk_box, w_win_box;
    logic        w_chk_flag, w_chk_valid;
    logic [23:0] w_chk_area, w_best_area;
    cls_e        w_best;
    logic [3:0]  w_stable_next;
    logic [7:0]  w_lost_next;

    // One checker shared across the three CALC states
    always_comb begin
        w_chk_box  = snap_q[0];
        w_chk_flag = snap_flag_q[0];
        case (state_q)
            ST_CALC_G: begin w_chk_box = snap_q[1]; w_chk_flag = snap_flag_q[1]; end
            ST_CALC_B: begin w_chk_box = snap_q[2]; w_chk_flag = snap_flag_q[2]; end
            default:   begin end
        endcase
    end

    box_area_check #(
        .MIN_AREA (MIN_AREA)
    ) u_area_check (
        .i_box   (w_chk_box),
        .i_flag  (w_chk_flag),
        .o_valid (w_chk_valid),
        .o_area  (w_chk_area)
    );

    // Strict '>' gives ties to the earlier channel, i.e. R > G > B
    always_comb begin
        w_best      = CLS_NONE;
        w_best_area = 24'd0;
        if (valid_q[0]) begin
            w_best      = CLS_R;
            w_best_area = area_q[0];
        end
        if (valid_q[1] && (area_q[1] > w_best_area)) begin
            w_best      = CLS_G;
            w_best_area = area_q[1];
        end
        if (valid_q[2] && (area_q[2] > w_best_area)) begin
            w_best      = CLS_B;
            w_best_area = area_q[2];
        end
    end

    always_comb begin
        case (winner_q)
            CLS_G:   w_win_box = snap_q[1];
            CLS_B:   w_win_box = snap_q[2];
            default: w_win_box = snap_q[0];
        endcase
        if (winner_q == pending_q) begin
            w_stable_next = (stable_q == c_hold) ? stable_q : stable_q + 4'd1;
        end else begin
            w_stable_next = 4'd1;
        end
        w_lost_next = (lost_q == c_lost) ? lost_q : lost_q + 8'd1;
    end

    assign w_start = i_vsync && !vsync_q && (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        vsync_d     = i_vsync;
        cand_d      = cand_q;
        flag_d      = flag_q;
        snap_d      = snap_q;
        snap_flag_d = snap_flag_q;
        valid_d     = valid_q;
        area_d      = area_q;
        winner_d    = winner_q;
        pending_d   = pending_q;
        disp_d      = disp_q;
        stable_d    = stable_q;
        lost_d      = lost_q;
        disp_box_d  = disp_box_q;

        if (w_start) begin
            snap_d      = cand_q;
            snap_flag_d = flag_q;
            flag_d      = 3'b000;
        end
        // Pulses land after the frame-edge clear, so they belong to the new frame
        if (r_box_valid) begin cand_d[0] = r_box; flag_d[0] = 1'b1; end
        if (g_box_valid) begin cand_d[1] = g_box; flag_d[1] = 1'b1; end
        if (b_box_valid) begin cand_d[2] = b_box; flag_d[2] = 1'b1; end

        case (state_q)
            ST_IDLE: begin
                if (w_start) state_d = ST_CALC_R;
            end
            ST_CALC_R: begin
                valid_d[0] = w_chk_valid;
                area_d[0]  = w_chk_area;
                state_d    = ST_CALC_G;
            end
            ST_CALC_G: begin
                valid_d[1] = w_chk_valid;
                area_d[1]  = w_chk_area;
                state_d    = ST_CALC_B;
            end
            ST_CALC_B: begin
                valid_d[2] = w_chk_valid;
                area_d[2]  = w_chk_area;
                state_d    = ST_DECIDE;
            end
            ST_DECIDE: begin
                winner_d = w_best;
                state_d  = ST_COMMIT;
            end
            ST_COMMIT: begin
                pending_d = winner_q;
                stable_d  = w_stable_next;
                if (winner_q != CLS_NONE) begin
                    lost_d = 8'd0;
                    if (winner_q == disp_q) begin
                        disp_box_d = w_win_box;
                    end else if (w_stable_next == c_hold) begin
                        disp_d     = winner_q;
                        disp_box_d = w_win_box;
                    end
                end else begin
                    lost_d = w_lost_next;
                    if (w_lost_next == c_lost) begin
                        disp_d     = CLS_NONE;
                        disp_box_d = 48'd0;
                    end
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            vsync_q     <= 1'b0;
            cand_q      <= '0;
            flag_q      <= 3'b000;
            snap_q      <= '0;
            snap_flag_q <= 3'b000;
            valid_q     <= 3'b000;
            area_q      <= '0;
            winner_q    <= CLS_NONE;
            pending_q   <= CLS_NONE;
            disp_q      <= CLS_NONE;
            stable_q    <= 4'd0;
            lost_q      <= 8'd0;
            disp_box_q  <= 48'd0;
        end else begin
            state_q     <= state_d;
            vsync_q     <= vsync_d;
            cand_q      <= cand_d;
            flag_q      <= flag_d;
            snap_q      <= snap_d;
            snap_flag_q <= snap_flag_d;
            valid_q     <= valid_d;
            area_q      <= area_d;
            winner_q    <= winner_d;
            pending_q   <= pending_d;
            disp_q      <= disp_d;
            stable_q    <= stable_d;
            lost_q      <= lost_d;
            disp_box_q  <= disp_box_d;
        end
    end

    assign hcount_l = disp_box_q[c_hl_lsb +: c_field_w];
    assign hcount_r = disp_box_q[c_hr_lsb +: c_field_w];
    assign vcount_l = disp_box_q[c_vl_lsb +: c_field_w];
    assign vcount_r = disp_box_q[c_vr_lsb +: c_field_w];
    assign red_en   = (disp_q == CLS_R);
    assign grenn_en = (disp_q == CLS_G);
    assign blue_en  = (disp_q == CLS_B);
    assign r_t      = label_colour(disp_q);
    assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_box_arbiter.sv
`default_nettype none
// ============================================================================
// tb_box_arbiter : directed frame-by-frame vectors for box_arbiter
// Revision 1.0
// ============================================================================
module tb_box_arbiter;

    logic        pixelclk;
    logic        reset_n;
    logic        i_vsync;
    logic        rv, gv, bv;
    logic [47:0] rb, gb, bb;
    logic [11:0] hcount_l, hcount_r, vcount_l, vcount_r;
    logic        red_en, grenn_en, blue_en;
    logic [23:0] r_t;
    logic        busy;

    initial pixelclk = 1'b0;
    always #5 pixelclk = ~pixelclk;

    box_arbiter #(
        .FRAME_HOLD  (3),
        .MIN_AREA    (400),
        .LOST_FRAMES (8)
    ) dut (
        .pixelclk    (pixelclk),
        .reset_n     (reset_n),
        .i_vsync     (i_vsync),
        .r_box_valid (rv),
        .r_box       (rb),
        .g_box_valid (gv),
        .g_box       (gb),
        .b_box_valid (bv),
        .b_box       (bb),
        .hcount_l    (hcount_l),
        .hcount_r    (hcount_r),
        .vcount_l    (vcount_l),
        .vcount_r    (vcount_r),
        .red_en      (red_en),
        .grenn_en    (grenn_en),
        .blue_en     (blue_en),
        .r_t         (r_t),
        .busy        (busy)
    );

    typedef struct {
        logic [47:0] rb;
        logic [47:0] gb;
        logic [47:0] bb;
        logic        oe;
        logic [2:0]  en;
        logic [23:0] rt;
        logic [47:0] box;
    } vec_t;

    vec_t        tbl[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [2:0]  prev_en;
    logic [23:0] prev_rt;
    logic [47:0] prev_box;

    logic [47:0] R0, R1, R2, R3, G40, BB, REQ, RBAD, RZ, B399, B400, Z;
    localparam logic [23:0] RED = 24'hff0000;
    localparam logic [23:0] GRN = 24'h00ff00;
    localparam logic [23:0] BLU = 24'h0000ff;

    function automatic logic [47:0] mk(input int hl, input int hr, input int vl, input int vr);
        return {12'(hl), 12'(hr), 12'(vl), 12'(vr)};
    endfunction

    function automatic logic [74:0] outs();
        return {red_en, grenn_en, blue_en, r_t, hcount_l, hcount_r, vcount_l, vcount_r};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // A zero box means "no pulse on that channel"
    task automatic add(input logic [47:0] r_b, input logic [47:0] g_b, input logic [47:0] b_b,
                       input logic oe, input logic [2:0] en, input logic [23:0] rt,
                       input logic [47:0] box);
        tbl.push_back('{r_b, g_b, b_b, oe, en, rt, box});
    endtask

    task automatic drive_pulses(input vec_t v);
        rv = (v.rb != 48'd0); rb = v.rb;
        gv = (v.gb != 48'd0); gb = v.gb;
        bv = (v.bb != 48'd0); bb = v.bb;
    endtask

    task automatic idle_pulses();
        rv = 1'b0; gv = 1'b0; bv = 1'b0;
    endtask

    // Frame edge in cycle E; commit visible after the 6th posedge
    task automatic run_frame(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("row%0d", idx);
        if (!v.oe) begin
            drive_pulses(v);
            @(posedge pixelclk); #1;
            idle_pulses();
        end
        i_vsync = 1'b1;
        if (v.oe) drive_pulses(v);
        @(posedge pixelclk); #1;
        i_vsync = 1'b0;
        idle_pulses();
        check({tag, "_busy_start"}, busy, 1);
        repeat (4) @(posedge pixelclk);
        #1;
        check({tag, "_held_before_commit"}, outs(), {prev_en, prev_rt, prev_box});
        check({tag, "_busy_commit"}, busy, 1);
        @(posedge pixelclk); #1;
        check({tag, "_en"}, {red_en, grenn_en, blue_en}, v.en);
        check({tag, "_rt"}, r_t, v.rt);
        check({tag, "_box"}, {hcount_l, hcount_r, vcount_l, vcount_r}, v.box);
        check({tag, "_busy_done"}, busy, 0);
        prev_en  = v.en;
        prev_rt  = v.rt;
        prev_box = v.box;
        repeat (2) @(posedge pixelclk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra;
        R0   = mk(100, 300,  50, 200);
        R1   = mk(110, 310,  60, 210);
        R2   = mk(120, 320,  70, 220);
        R3   = mk(130, 330,  80, 230);
        G40  = mk(0, 200, 0, 200);
        BB   = mk(0, 300, 0, 300);
        REQ  = mk(100, 300, 100, 300);
        RBAD = mk(300, 100, 0, 200);
        RZ   = mk(100, 100, 0, 200);
        B399 = mk(0, 21, 0, 19);
        B400 = mk(0, 20, 0, 20);
        Z    = 48'd0;

        // rows 1..3: debounce of a single red target
        add(R0, Z, Z, 0, 3'b000, 24'h0, Z);
        add(R0, Z, Z, 0, 3'b000, 24'h0, Z);
        add(R0, Z, Z, 0, 3'b100, RED, R0);
        // rows 4..8: tracking, then blue dominates 2 frames (held) and switches on the 3rd
        add(R1, Z, Z, 0, 3'b100, RED, R1);
        add(R2, Z, Z, 0, 3'b100, RED, R2);
        add(R3, Z, BB, 0, 3'b100, RED, R2);
        add(R3, Z, BB, 0, 3'b100, RED, R2);
        add(Z, Z, BB, 0, 3'b001, BLU, BB);
        // rows 9..11: equal areas, red wins the tie
        add(REQ, G40, Z, 0, 3'b001, BLU, BB);
        add(REQ, G40, Z, 0, 3'b001, BLU, BB);
        add(REQ, G40, Z, 0, 3'b100, RED, REQ);
        // rows 12..14: larger green beats red
        add(R0, G40, Z, 0, 3'b100, RED, REQ);
        add(R0, G40, Z, 0, 3'b100, RED, REQ);
        add(R0, G40, Z, 0, 3'b010, GRN, G40);
        // rows 15..22: invalid boxes then silence; held 7 commits, cleared on the 8th
        add(RBAD, Z, B399, 0, 3'b010, GRN, G40);
        add(RZ, Z, Z, 0, 3'b010, GRN, G40);
        for (int i = 0; i < 5; i++) add(Z, Z, Z, 0, 3'b010, GRN, G40);
        add(Z, Z, Z, 0, 3'b000, 24'h0, Z);
        // rows 23..25: area exactly MIN_AREA is valid
        add(Z, Z, B400, 0, 3'b000, 24'h0, Z);
        add(Z, Z, B400, 0, 3'b000, 24'h0, Z);
        add(Z, Z, B400, 0, 3'b001, BLU, B400);
        // rows 26..31: a pulse on the edge cycle counts toward the next frame
        add(R0, Z, Z, 0, 3'b001, BLU, B400);
        add(R0, Z, Z, 0, 3'b001, BLU, B400);
        add(R0, Z, Z, 1, 3'b001, BLU, B400);
        add(Z, Z, Z, 0, 3'b001, BLU, B400);
        add(R0, Z, Z, 0, 3'b001, BLU, B400);
        add(R0, Z, Z, 0, 3'b100, RED, R0);
        // rows 32..34: after a mid-arbitration reset, debounce restarts
        add(R0, Z, Z, 0, 3'b000, 24'h0, Z);
        add(R0, Z, Z, 0, 3'b000, 24'h0, Z);
        add(R0, Z, Z, 0, 3'b100, RED, R0);

        reset_n = 1'b0;
        i_vsync = 1'b0;
        idle_pulses();
        rb = '0; gb = '0; bb = '0;
        repeat (3) @(posedge pixelclk);
        #1;
        check("reset_outs", outs(), 0);
        check("reset_busy", busy, 0);
        reset_n = 1'b1;
        @(posedge pixelclk); #1;
        check("post_reset_outs", outs(), 0);
        prev_en = 3'b000; prev_rt = 24'h0; prev_box = 48'd0;

        for (int i = 0; i < 31; i++) run_frame(tbl[i], i + 1);

        // Second vsync edge during arbitration must not start another pass
        i_vsync = 1'b1;
        @(posedge pixelclk); #1;
        i_vsync = 1'b0;
        @(posedge pixelclk); #1;
        i_vsync = 1'b1;
        @(posedge pixelclk); #1;
        i_vsync = 1'b0;
        repeat (3) @(posedge pixelclk);
        #1;
        check("busy_edge_commit_done", busy, 0);
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            if (busy) extra++;
            @(posedge pixelclk); #1;
        end
        check("busy_edge_ignored", extra, 0);
        check("busy_edge_outs_held", outs(), {3'b100, RED, R0});

        // Reset asserted while in CALC_G
        rv = 1'b1; rb = R0;
        @(posedge pixelclk); #1;
        idle_pulses();
        i_vsync = 1'b1;
        @(posedge pixelclk); #1;
        i_vsync = 1'b0;
        @(posedge pixelclk); #1;
        check("busy_before_reset", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_mid_outs", outs(), 0);
        check("reset_mid_busy", busy, 0);
        @(posedge pixelclk); #1;
        reset_n = 1'b1;
        prev_en = 3'b000; prev_rt = 24'h0; prev_box = 48'd0;
        repeat (2) @(posedge pixelclk);
        #1;

        for (int i = 31; i < 34; i++) run_frame(tbl[i], i + 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
